data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, 256, memory depth in 32-bit words; power of two, 16..4096.
REQ-002 Parameter: WAIT_CYCLES, 2, added wait states per access; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1  one-cycle pulse: access complete.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  access rejected (qualified by resp_valid).

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 Handshake: request accepted on an edge where req_valid && req_ready; all req_* fields latched at that edge and ignored thereafter until the next IDLE.
REQ-017 Accept in IDLE: to WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES > 0, else directly to RESP.
REQ-018 WAIT: counter decrements each cycle; at 0, next state RESP.
REQ-019 RESP: resp_valid = 1 for exactly one cycle, no backpressure; next state IDLE unconditionally.
REQ-020 Latency: resp_valid high in cycle WAIT_CYCLES+1 after the accept edge; back-to-back throughput one access per WAIT_CYCLES+2 cycles.
REQ-021 Store commit and load capture occur on the edge entering RESP; resp_rdata/resp_err are registered and valid only while resp_valid = 1, otherwise 0.
REQ-022 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing wrap-around, no error).
REQ-023 Byte access: lane req_addr[1:0]; halfword: lane req_addr[1]; word: whole word; store writes only the addressed lanes, other bytes unchanged.
REQ-024 Load: selected byte/half extended to 32 bits per req_unsigned; word returned unchanged.
REQ-025 A load issued after a store to the same address returns the stored data (no stale read).
REQ-026 req_valid asserted outside IDLE has no effect; initiator holds it until req_ready.

Reset
REQ-027 reset asserted: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 1 after release.
REQ-028 reset during WAIT aborts the access; an uncommitted store does not modify memory.
REQ-029 Memory array contents are not cleared by reset.

Configuration
REQ-030 Macro DMEM_ALIGN_CHECK_EN defined: halfword with req_addr[0] = 1 or word with req_addr[1:0] != 0 is misaligned; responds with normal latency, resp_err = 1, resp_rdata = 0, no memory write.
REQ-031 Macro undefined: no alignment check; halfword ignores req_addr[0], word ignores req_addr[1:0]; resp_err tied 0.

Verification
REQ-032 WAIT_CYCLES=2: store word 0xDEADBEEF @0x10, load word @0x10 -> resp_valid 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-033 Store byte 0x80 @0x13 over 0x00000000, load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x80000000.
REQ-034 DEPTH_WORDS=256: store word 0x12345678 @0x400, load @0x000 -> 0x12345678 (alias wrap).
REQ-035 Load half @0x11: with DMEM_ALIGN_CHECK_EN -> err 1, rdata 0; without -> err 0, data of half @0x10.
REQ-036 Store 0xA5A5A5A5 @0x20, assert reset in WAIT, then load @0x20 -> previous contents, req_ready 1 first cycle after reset release.
REQ-037 WAIT_CYCLES=0: req_valid held high continuously -> accepts every 2nd cycle, resp_valid single-cycle pulses, req_ready low in RESP.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory answering load/store requests after WAIT_CYCLES wait states.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses with resp_err.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, uns_q, err_q;
    logic [1:0]    size_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q, rdata_q, rdata_d;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          idle, enter_resp, commit, misal, a_we, a_uns;
    logic [1:0]    a_size;
    logic [AW+1:0] a_addr;
    logic [31:0]   a_wdata, word, wd;
    logic [3:0]    be;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic          unused_addr;

    assign unused_addr = &{1'b0, req_addr[31:AW+2]};

    // In IDLE the access may complete on the accept edge itself, so use the live request there.
    assign idle    = state_q == IDLE;
    assign a_we    = idle ? req_we : we_q;
    assign a_uns   = idle ? req_unsigned : uns_q;
    assign a_size  = idle ? req_size : size_q;
    assign a_addr  = idle ? req_addr[AW+1:0] : addr_q;
    assign a_wdata = idle ? req_wdata : wdata_q;

    assign word     = mem[a_addr[AW+1:2]];
    assign byte_sel = 8'(word >> {a_addr[1:0], 3'b000});
    assign half_sel = a_addr[1] ? word[31:16] : word[15:0];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misal = a_size[1] ? |a_addr[1:0] : a_size[0] & a_addr[0];
`else
    assign misal = 1'b0;
`endif

    assign be = a_size[1] ? 4'hf : a_size[0] ? (a_addr[1] ? 4'hc : 4'h3) : 4'b0001 << a_addr[1:0];
    assign wd = a_size[1] ? a_wdata : a_size[0] ? {2{a_wdata[15:0]}} : {4{a_wdata[7:0]}};

    assign rdata_d = (a_we || misal) ? 32'h0 :
                     a_size[1] ? word :
                     a_size[0] ? {{16{~a_uns & half_sel[15]}}, half_sel} :
                                 {{24{~a_uns & byte_sel[7]}}, byte_sel};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && req_valid) begin
            state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            cnt_d   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'h0;
        end else if (state_q == WAIT) begin
            state_d = (cnt_q == 4'h0) ? RESP : WAIT;
            cnt_d   = (cnt_q == 4'h0) ? 4'h0 : cnt_q - 4'h1;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    assign enter_resp = state_d == RESP && state_q != RESP;
    assign commit     = enter_resp && a_we && !misal && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= enter_resp ? rdata_d : 32'h0;
            err_q   <= enter_resp && misal;
            if (idle && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
            end
        end
    end

    // Memory contents survive reset; only the addressed byte lanes are written.
    always_ff @(posedge clk) begin
        if (commit)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[a_addr[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
    end

    assign req_ready  = idle;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of data_mem_responder with WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_valid0 = 1'b0;
    logic        req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd2;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err));

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0));

    // One access on dut: lat = cycles after the accept edge until resp_valid (0 = timed out);
    // clean = 0 if rdata/err were nonzero while resp_valid was low.
    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdat,
                          output logic [31:0] rd, output logic er, output int lat, output logic clean);
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdat;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; clean = 1'b1; rd = '0; er = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i; rd = resp_rdata; er = resp_err;
            end else if (resp_rdata !== 32'h0 || resp_err !== 1'b0) clean = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++;
        if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
        checks++;
        if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", resp_err); end
        checks++;
        reset = 1'b0;
        #1;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er, cl; int lat;
        access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, cl);
        if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d exp 3", lat); end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL store_resp got %h/%b exp 0/0", rd, er); end
        checks++;
        if (cl !== 1'b1) begin errors++; $display("FAIL store_idle_outputs got %b exp 1", cl); end
        checks++;
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, cl);
        if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d exp 3", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_word got %h exp deadbeef", rd); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL load_word_err got %b exp 0", er); end
        checks++;
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er, cl; int lat;
        access(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, cl);
        access(1'b1, 2'd0, 1'b0, 32'h13, 32'h12345680, rd, er, lat, cl);
        access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er, lat, cl);
        if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_signed got %h exp ffffff80", rd); end
        checks++;
        access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er, lat, cl);
        if (rd !== 32'h00000080) begin errors++; $display("FAIL byte_unsigned got %h exp 00000080", rd); end
        checks++;
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, cl);
        if (rd !== 32'h80000000) begin errors++; $display("FAIL byte_merge_word got %h exp 80000000", rd); end
        checks++;
        access(1'b1, 2'd2, 1'b0, 32'h14, 32'h11223344, rd, er, lat, cl);
        access(1'b1, 2'd1, 1'b0, 32'h16, 32'h9999BEEF, rd, er, lat, cl);
        access(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, rd, er, lat, cl);
        if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL half_signed got %h exp ffffbeef", rd); end
        checks++;
        access(1'b0, 2'd1, 1'b1, 32'h14, 32'h0, rd, er, lat, cl);
        if (rd !== 32'h00003344) begin errors++; $display("FAIL half_unsigned got %h exp 00003344", rd); end
        checks++;
        access(1'b0, 2'd0, 1'b0, 32'h15, 32'h0, rd, er, lat, cl);
        if (rd !== 32'h00000033) begin errors++; $display("FAIL byte_lane1 got %h exp 00000033", rd); end
        checks++;
        access(1'b0, 2'd3, 1'b0, 32'h14, 32'h0, rd, er, lat, cl);
        if (rd !== 32'hBEEF3344) begin errors++; $display("FAIL size3_word got %h exp beef3344", rd); end
        checks++;
    endtask

    task automatic test_alias();
        logic [31:0] rd; logic er, cl; int lat;
        access(1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, rd, er, lat, cl);
        access(1'b0, 2'd2, 1'b0, 32'h000, 32'h0, rd, er, lat, cl);
        if (rd !== 32'h12345678 || er !== 1'b0) begin errors++; $display("FAIL alias_wrap got %h/%b exp 12345678/0", rd, er); end
        checks++;
    endtask

    task automatic test_misalign();
        logic [31:0] rd, exp_rd, exp_word; logic er, cl, exp_er; int lat;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_rd = 32'h0; exp_er = 1'b1; exp_word = 32'h1234ABCD;
`else
        exp_rd = 32'hFFFFABCD; exp_er = 1'b0; exp_word = 32'h55667788;
`endif
        access(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234ABCD, rd, er, lat, cl);
        access(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, rd, er, lat, cl);
        if (rd !== exp_rd || er !== exp_er) begin errors++; $display("FAIL misaligned_half got %h/%b exp %h/%b", rd, er, exp_rd, exp_er); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL misaligned_latency got %0d exp 3", lat); end
        checks++;
        access(1'b1, 2'd2, 1'b0, 32'h12, 32'h55667788, rd, er, lat, cl);
        if (er !== exp_er) begin errors++; $display("FAIL misaligned_store_err got %b exp %b", er, exp_er); end
        checks++;
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, cl);
        if (rd !== exp_word) begin errors++; $display("FAIL misaligned_store_effect got %h exp %h", rd, exp_word); end
        checks++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er, cl; int lat;
        access(1'b1, 2'd2, 1'b0, 32'h20, 32'h0BADF00D, rd, er, lat, cl);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL abort_ready got %b/%b exp 1/0", req_ready, resp_valid); end
        checks++;
        repeat (3) @(negedge clk);
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_resp got %b exp 0", resp_valid); end
        checks++;
        access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, cl);
        if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL abort_no_write got %h exp 0badf00d", rd); end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er, cl; int lat;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_addr = 32'h30; req_wdata = 32'h11111111; req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) begin req_addr = 32'h34; req_wdata = 32'h22222222; end
            if (req_ready !== (i % 4 == 0)) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", i, req_ready, i % 4 == 0); end
            checks++;
            if (resp_valid !== (i % 4 == 3)) begin errors++; $display("FAIL b2b_resp_valid[%0d] got %b exp %b", i, resp_valid, i % 4 == 3); end
            checks++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat, cl);
        if (rd !== 32'h11111111) begin errors++; $display("FAIL b2b_latched_first got %h exp 11111111", rd); end
        checks++;
        access(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, rd, er, lat, cl);
        if (rd !== 32'h22222222) begin errors++; $display("FAIL b2b_second got %h exp 22222222", rd); end
        checks++;
    endtask

    task automatic test_zero_wait();
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_addr = 32'h8; req_wdata = 32'h000000AA; req_valid0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready0 !== (i % 2 == 0)) begin errors++; $display("FAIL w0_ready[%0d] got %b exp %b", i, req_ready0, i % 2 == 0); end
            checks++;
            if (resp_valid0 !== (i % 2 == 1)) begin errors++; $display("FAIL w0_resp_valid[%0d] got %b exp %b", i, resp_valid0, i % 2 == 1); end
            checks++;
        end
        @(negedge clk);
        req_valid0 = 1'b0;
        @(negedge clk);
        req_we = 1'b0; req_valid0 = 1'b1;
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        @(negedge clk);
        if (resp_valid0 !== 1'b1 || resp_rdata0 !== 32'h000000AA) begin errors++; $display("FAIL w0_load got %b/%h exp 1/000000aa", resp_valid0, resp_rdata0); end
        checks++;
        @(negedge clk);
        if (resp_valid0 !== 1'b0 || resp_rdata0 !== 32'h0) begin errors++; $display("FAIL w0_pulse_end got %b/%h exp 0/0", resp_valid0, resp_rdata0); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_alias();
        test_misalign();
        test_reset_abort();
        test_back_to_back();
        test_zero_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
